multiport_circular_queue: RTL

//   Superscalar circular queue: up to SS entries allocated and up to SS retired per cycle.
//   Per-slot update and read ports give random access to live entries.

---
 rtl/multiport_circular_queue.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/multiport_circular_queue.sv
`default_nettype none
// ============================================================================
// Module   : multiport_circular_queue
// Purpose  : Superscalar circular queue. Up to SS entries are pushed at the
//            tail and up to SS retired from the head each cycle. Random-access
//            update ports overwrite live entries, and random-access read ports
//            return live entries one cycle later. Flush empties the queue in
//            a single cycle.
// Ports    : clk, rst                      clock, sync active-high reset
//            flush_i                       discard all entries
//            push_cnt_i/push_data_i        allocate group at tail
//            push_ok_o, alloc_idx_o        group acceptance, lane slot indices
//            pop_cnt_i/pop_ok_o            retire group from head
//            head_data_o/head_vld_o        oldest SS entries
//            upd_en_i/upd_idx_i/upd_data_i random-access writes
//            rd_en_i/rd_idx_i              random-access read requests
//            rd_data_o/rd_vld_o            registered read results
//            occ_cnt_o/full_o/empty_o      occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module multiport_circular_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int SS    = 4,
  parameter int UPD   = 4,
  parameter int RDP   = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(SS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [CNT_W-1:0]       push_cnt_i,
  input  logic [SS*WIDTH-1:0]    push_data_i,
  output logic                   push_ok_o,
  input  logic [CNT_W-1:0]       pop_cnt_i,
  output logic                   pop_ok_o,
  output logic [SS*WIDTH-1:0]    head_data_o,
  output logic [SS-1:0]          head_vld_o,
  output logic [SS*PTR_W-1:0]    alloc_idx_o,
  input  logic [UPD-1:0]         upd_en_i,
  input  logic [UPD*PTR_W-1:0]   upd_idx_i,
  input  logic [UPD*WIDTH-1:0]   upd_data_i,
  input  logic [RDP-1:0]         rd_en_i,
  input  logic [RDP*PTR_W-1:0]   rd_idx_i,
  output logic [RDP*WIDTH-1:0]   rd_data_o,
  output logic [RDP-1:0]         rd_vld_o,
  output logic [PTR_W:0]         occ_cnt_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int OCC_W = PTR_W + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [OCC_W-1:0]     head_q, tail_q;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [RDP*WIDTH-1:0] rd_data_q, rd_data_d;
  logic [RDP-1:0]       rd_vld_q, rd_vld_d;

  logic [OCC_W-1:0]     w_occ, w_free;
  logic                 w_push_ok, w_pop_ok;
  logic [SS-1:0]        w_push_lane, w_pop_lane;
  logic [PTR_W-1:0]     w_push_slot [SS];
  logic [PTR_W-1:0]     w_pop_slot  [SS];
  logic [DEPTH-1:0]     w_push_mask, w_pop_mask;
  logic [UPD-1:0]       w_upd_ok;

  assign w_occ  = tail_q - head_q;
  assign w_free = OCC_W'(DEPTH) - w_occ;

  // Acceptance uses pre-edge occupancy only: space freed by a same-cycle pop
  // is not offered to the push group.
  assign w_push_ok = (push_cnt_i <= CNT_W'(SS)) && (OCC_W'(push_cnt_i) <= w_free);
  assign w_pop_ok  = (pop_cnt_i  <= CNT_W'(SS)) && (OCC_W'(pop_cnt_i)  <= w_occ);

  assign push_ok_o = w_push_ok;
  assign pop_ok_o  = w_pop_ok;
  assign occ_cnt_o = w_occ;
  assign full_o    = (w_occ == OCC_W'(DEPTH));
  assign empty_o   = (w_occ == '0);

  generate
    for (genvar i = 0; i < SS; i++) begin : g_lane
      assign w_push_slot[i] = tail_q[PTR_W-1:0] + PTR_W'(i);
      assign w_pop_slot[i]  = head_q[PTR_W-1:0] + PTR_W'(i);
      assign w_push_lane[i] = w_push_ok && !flush_i && (CNT_W'(i) < push_cnt_i);
      assign w_pop_lane[i]  = w_pop_ok  && !flush_i && (CNT_W'(i) < pop_cnt_i);
      assign alloc_idx_o[i*PTR_W +: PTR_W] = w_push_slot[i];
      assign head_data_o[i*WIDTH +: WIDTH] = mem_q[w_pop_slot[i]];
      assign head_vld_o[i] = (OCC_W'(i) < w_occ);
    end
  endgenerate

  always_comb begin
    w_push_mask = '0;
    w_pop_mask  = '0;
    for (int i = 0; i < SS; i++) begin
      if (w_push_lane[i]) w_push_mask[w_push_slot[i]] = 1'b1;
      if (w_pop_lane[i])  w_pop_mask[w_pop_slot[i]]   = 1'b1;
    end
    // Push slots are free pre-edge and pop slots are live, so they never overlap.
    valid_d = (valid_q & ~w_pop_mask) | w_push_mask;
  end

  generate
    for (genvar k = 0; k < UPD; k++) begin : g_upd
      // An update only lands on a slot that stays live across this edge.
      assign w_upd_ok[k] = upd_en_i[k] && !flush_i
                           && valid_q[upd_idx_i[k*PTR_W +: PTR_W]]
                           && !w_pop_mask[upd_idx_i[k*PTR_W +: PTR_W]];
    end

    for (genvar k = 0; k < RDP; k++) begin : g_rd
      logic [PTR_W-1:0] w_rd_slot;
      assign w_rd_slot   = rd_idx_i[k*PTR_W +: PTR_W];
      assign rd_vld_d[k] = rd_en_i[k] && valid_q[w_rd_slot];
      assign rd_data_d[k*WIDTH +: WIDTH] = rd_vld_d[k] ? mem_q[w_rd_slot] : '0;
    end
  endgenerate

  // Payload storage is not reset. Updates are applied in ascending port order
  // so the highest-numbered port wins on a shared slot.
  always_ff @(posedge clk) begin
    for (int k = 0; k < UPD; k++) begin
      if (w_upd_ok[k]) mem_q[upd_idx_i[k*PTR_W +: PTR_W]] <= upd_data_i[k*WIDTH +: WIDTH];
    end
    for (int i = 0; i < SS; i++) begin
      if (w_push_lane[i]) mem_q[w_push_slot[i]] <= push_data_i[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      valid_q   <= '0;
      rd_vld_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (w_pop_ok)  head_q <= head_q + OCC_W'(pop_cnt_i);
      if (w_push_ok) tail_q <= tail_q + OCC_W'(push_cnt_i);
      valid_q   <= valid_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_vld_o  = rd_vld_q;

endmodule
`default_nettype wire
